// File: rtl/wb_queue.sv
// Writeback queue: merges load/ALU results into an oldest-first FIFO and drains one regfile write per cycle
// (accept at edge N, write driven after N+1); rdy comes from registered occupancy, refused valids set sticky ovf.
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 6,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mem_valid,
    input  logic [AW-1:0]            mem_rd,
    input  logic [DW-1:0]            mem_data,
    output logic                     mem_rdy,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_rd,
    input  logic [DW-1:0]            alu_data,
    output logic                     alu_rdy,
    output logic                     rw,
    output logic [AW-1:0]            rdi,
    output logic [DW-1:0]            wd,
    input  logic [AW-1:0]            chk_rd,
    output logic                     hit,
    output logic [DW-1:0]            hit_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        q [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] alu_idx;
    logic [CW-1:0] free;
    logic [CW-1:0] push_n;
    logic          mem_push;
    logic          alu_push;
    logic          pop;

    // Readiness deliberately ignores the same-cycle pop to keep rdy off the pop path.
    assign free     = CW'(DEPTH) - count;
    assign mem_rdy  = (free >= CW'(1));
    assign alu_rdy  = (free >= CW'(2)) | (mem_rdy & ~mem_valid);
    assign mem_push = mem_valid & mem_rdy;
    assign alu_push = alu_valid & alu_rdy;
    assign pop      = (count != '0);
    assign push_n   = CW'(mem_push) + CW'(alu_push);
    assign alu_idx  = wptr + PW'(mem_push);

    // Storage needs no reset: occupancy and pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (mem_push) q[wptr]    <= '{rd: mem_rd, data: mem_data};
        if (alu_push) q[alu_idx] <= '{rd: alu_rd, data: alu_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            rw    <= 1'b0;
            rdi   <= '0;
            wd    <= '0;
            ovf   <= 1'b0;
        end else begin
            wptr  <= wptr + push_n[PW-1:0];
            rptr  <= rptr + PW'(pop);
            count <= count + push_n - CW'(pop);
            rw    <= pop;
            if (pop) begin
                rdi <= q[rptr].rd;
                wd  <= q[rptr].data;
            end
            if ((mem_valid & ~mem_rdy) | (alu_valid & ~alu_rdy))
                ovf <= 1'b1;
        end
    end

    // Scan head to tail so later (younger) matches overwrite; output stage is oldest of all.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        hit      = rw && (rdi == chk_rd);
        hit_data = hit ? wd : '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rptr + PW'(i);
            if ((CW'(i) < count) && (q[idx].rd == chk_rd)) begin
                hit      = 1'b1;
                hit_data = q[idx].data;
            end
        end
    end
endmodule

// File: tb/tb_wb_queue.sv
module tb_wb_queue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid, alu_valid;
    logic [5:0]  mem_rd, alu_rd, chk_rd;
    logic [31:0] mem_data, alu_data;
    logic        mem_rdy, alu_rdy, rw, hit, ovf;
    logic [5:0]  rdi;
    logic [31:0] wd, hit_data;
    logic [2:0]  count;
    int          errors = 0;
    int          checks = 0;

    wb_queue #(.DEPTH(4), .AW(6), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_rdy(mem_rdy),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_rdy(alu_rdy),
        .rw(rw), .rdi(rdi), .wd(wd), .chk_rd(chk_rd), .hit(hit), .hit_data(hit_data),
        .count(count), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        mem_valid = 1'b0; alu_valid = 1'b0;
        mem_rd = '0; alu_rd = '0; mem_data = '0; alu_data = '0;
    endtask

    task automatic test_reset;
        checks++;
        if (rw !== 1'b0 || count !== 3'd0 || ovf !== 1'b0 || rdi !== 6'd0 || wd !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: rw=%0b count=%0d ovf=%0b rdi=%0d wd=%h, expected 0 0 0 0 0", rw, count, ovf, rdi, wd);
        end
        checks++;
        if (mem_rdy !== 1'b1 || alu_rdy !== 1'b1 || hit !== 1'b0) begin
            errors++;
            $display("FAIL reset_rdy: mem_rdy=%0b alu_rdy=%0b hit=%0b, expected 1 1 0", mem_rdy, alu_rdy, hit);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step;
        checks++;
        if (rw !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL reset_idle: rw=%0b count=%0d, expected 0 0", rw, count);
        end
    endtask

    task automatic test_single_alu;
        alu_valid = 1'b1; alu_rd = 6'd5; alu_data = 32'h1234;
        step;
        idle_inputs;
        checks++;
        if (count !== 3'd1 || rw !== 1'b0) begin
            errors++;
            $display("FAIL single_queued: count=%0d rw=%0b, expected 1 0", count, rw);
        end
        step;
        checks++;
        if (rw !== 1'b1 || rdi !== 6'd5 || wd !== 32'h1234 || count !== 3'd0) begin
            errors++;
            $display("FAIL single_write: rw=%0b rdi=%0d wd=%h count=%0d, expected 1 5 00001234 0", rw, rdi, wd, count);
        end
        step;
        checks++;
        if (rw !== 1'b0 || rdi !== 6'd5 || wd !== 32'h1234) begin
            errors++;
            $display("FAIL single_after: rw=%0b rdi=%0d wd=%h, expected 0 5 00001234", rw, rdi, wd);
        end
    endtask

    task automatic test_dual_push;
        mem_valid = 1'b1; mem_rd = 6'd3; mem_data = 32'hA;
        alu_valid = 1'b1; alu_rd = 6'd4; alu_data = 32'hB;
        step;
        idle_inputs;
        checks++;
        if (count !== 3'd2) begin
            errors++;
            $display("FAIL dual_count: count=%0d, expected 2", count);
        end
        step;
        checks++;
        if (rw !== 1'b1 || rdi !== 6'd3 || wd !== 32'hA) begin
            errors++;
            $display("FAIL dual_first: rw=%0b rdi=%0d wd=%h, expected 1 3 0000000a", rw, rdi, wd);
        end
        step;
        checks++;
        if (rw !== 1'b1 || rdi !== 6'd4 || wd !== 32'hB || count !== 3'd0) begin
            errors++;
            $display("FAIL dual_second: rw=%0b rdi=%0d wd=%h count=%0d, expected 1 4 0000000b 0", rw, rdi, wd, count);
        end
        step;
        checks++;
        if (rw !== 1'b0) begin
            errors++;
            $display("FAIL dual_idle: rw=%0b, expected 0", rw);
        end
    endtask

    task automatic test_bypass;
        chk_rd = 6'd7;
        alu_valid = 1'b1; alu_rd = 6'd7; alu_data = 32'h11;
        step;
        alu_data = 32'h22;
        #1;
        checks++;
        if (hit !== 1'b1 || hit_data !== 32'h11) begin
            errors++;
            $display("FAIL bypass_one: hit=%0b data=%h, expected 1 00000011", hit, hit_data);
        end
        step;
        idle_inputs;
        #1;
        checks++;
        if (hit !== 1'b1 || hit_data !== 32'h22 || rw !== 1'b1 || wd !== 32'h11) begin
            errors++;
            $display("FAIL bypass_queue_over_out: hit=%0b data=%h rw=%0b wd=%h, expected 1 00000022 1 00000011", hit, hit_data, rw, wd);
        end
        chk_rd = 6'd8;
        #1;
        checks++;
        if (hit !== 1'b0 || hit_data !== 32'd0) begin
            errors++;
            $display("FAIL bypass_miss: hit=%0b data=%h, expected 0 00000000", hit, hit_data);
        end
        chk_rd = 6'd7;
        step;
        checks++;
        if (hit !== 1'b1 || hit_data !== 32'h22 || count !== 3'd0) begin
            errors++;
            $display("FAIL bypass_out_stage: hit=%0b data=%h count=%0d, expected 1 00000022 0", hit, hit_data, count);
        end
        step;
        checks++;
        if (hit !== 1'b0 || hit_data !== 32'd0) begin
            errors++;
            $display("FAIL bypass_drained: hit=%0b data=%h, expected 0 00000000", hit, hit_data);
        end
        mem_valid = 1'b1; mem_rd = 6'd7; mem_data = 32'h33;
        alu_valid = 1'b1; alu_rd = 6'd7; alu_data = 32'h44;
        step;
        idle_inputs;
        #1;
        checks++;
        if (hit !== 1'b1 || hit_data !== 32'h44) begin
            errors++;
            $display("FAIL bypass_tail_wins: hit=%0b data=%h, expected 1 00000044", hit, hit_data);
        end
        step; step; step;
        checks++;
        if (rw !== 1'b0 || count !== 3'd0 || hit !== 1'b0) begin
            errors++;
            $display("FAIL bypass_settle: rw=%0b count=%0d hit=%0b, expected 0 0 0", rw, count, hit);
        end
        chk_rd = 6'd0;
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 12; i++) begin
            alu_valid = 1'b1; alu_rd = 6'(i); alu_data = 32'(i);
            step;
            if (i > 0) begin
                checks++;
                if (rw !== 1'b1 || rdi !== 6'(i - 1) || wd !== 32'(i - 1) || count !== 3'd1) begin
                    errors++;
                    $display("FAIL wrap_%0d: rw=%0b rdi=%0d wd=%0d count=%0d, expected 1 %0d %0d 1", i, rw, rdi, wd, count, i - 1, i - 1);
                end
            end
        end
        idle_inputs;
        step;
        checks++;
        if (rw !== 1'b1 || rdi !== 6'd11 || wd !== 32'd11 || count !== 3'd0) begin
            errors++;
            $display("FAIL wrap_last: rw=%0b rdi=%0d wd=%0d count=%0d, expected 1 11 11 0", rw, rdi, wd, count);
        end
        step;
        checks++;
        if (rw !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end: rw=%0b ovf=%0b, expected 0 0", rw, ovf);
        end
    endtask

    task automatic test_fill;
        logic [5:0] exp_rd [6];
        exp_rd[0] = 6'd10; exp_rd[1] = 6'd11; exp_rd[2] = 6'd12;
        exp_rd[3] = 6'd13; exp_rd[4] = 6'd14; exp_rd[5] = 6'd0;
        mem_valid = 1'b1; mem_rd = 6'd10; mem_data = 32'h100;
        alu_valid = 1'b1; alu_rd = 6'd11; alu_data = 32'h101;
        step;
        mem_rd = 6'd12; mem_data = 32'h102; alu_rd = 6'd13; alu_data = 32'h103;
        #1;
        checks++;
        if (count !== 3'd2 || mem_rdy !== 1'b1 || alu_rdy !== 1'b1) begin
            errors++;
            $display("FAIL fill_c2: count=%0d mem_rdy=%0b alu_rdy=%0b, expected 2 1 1", count, mem_rdy, alu_rdy);
        end
        step;
        mem_rd = 6'd14; mem_data = 32'h104; alu_rd = 6'd15; alu_data = 32'h105;
        #1;
        checks++;
        if (count !== 3'd3 || mem_rdy !== 1'b1 || alu_rdy !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL fill_c3: count=%0d mem_rdy=%0b alu_rdy=%0b ovf=%0b, expected 3 1 0 0", count, mem_rdy, alu_rdy, ovf);
        end
        mem_valid = 1'b0;
        #1;
        checks++;
        if (alu_rdy !== 1'b1) begin
            errors++;
            $display("FAIL fill_alu_only: alu_rdy=%0b, expected 1", alu_rdy);
        end
        mem_valid = 1'b1;
        step;
        idle_inputs;
        checks++;
        if (ovf !== 1'b1 || count !== 3'd3 || rdi !== 6'd11) begin
            errors++;
            $display("FAIL fill_ovf: ovf=%0b count=%0d rdi=%0d, expected 1 3 11", ovf, count, rdi);
        end
        for (int k = 2; k < 6; k++) begin
            step;
            checks++;
            if ((k < 5 && (rw !== 1'b1 || rdi !== exp_rd[k] || wd !== 32'h100 + 32'(k))) || (k == 5 && rw !== 1'b0)) begin
                errors++;
                $display("FAIL fill_drain_%0d: rw=%0b rdi=%0d wd=%h, expected rd %0d (rw=0 at end)", k, rw, rdi, wd, exp_rd[k]);
            end
        end
        checks++;
        if (count !== 3'd0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL fill_end: count=%0d ovf=%0b, expected 0 1", count, ovf);
        end
    endtask

    task automatic test_reset_midburst;
        mem_valid = 1'b1; mem_rd = 6'd1; mem_data = 32'h1;
        alu_valid = 1'b1; alu_rd = 6'd2; alu_data = 32'h2;
        step;
        mem_rd = 6'd3; mem_data = 32'h3; alu_rd = 6'd4; alu_data = 32'h4;
        step;
        checks++;
        if (count !== 3'd3 || rw !== 1'b1 || rdi !== 6'd1) begin
            errors++;
            $display("FAIL midburst_pre: count=%0d rw=%0b rdi=%0d, expected 3 1 1", count, rw, rdi);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rw !== 1'b0 || count !== 3'd0 || ovf !== 1'b0 || rdi !== 6'd0 || wd !== 32'd0) begin
            errors++;
            $display("FAIL midburst_reset: rw=%0b count=%0d ovf=%0b rdi=%0d wd=%h, expected 0 0 0 0 0", rw, count, ovf, rdi, wd);
        end
        idle_inputs;
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step;
            checks++;
            if (rw !== 1'b0 || count !== 3'd0) begin
                errors++;
                $display("FAIL midburst_nowrite_%0d: rw=%0b count=%0d, expected 0 0", k, rw, count);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        chk_rd = '0;
        idle_inputs;
        #2;
        test_reset;
        test_single_alu;
        test_dual_push;
        test_bypass;
        test_wrap;
        test_fill;
        test_reset_midburst;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
